high_score_keeper: RTL and testbench

Downstream consumer of the score digit chain. On a game-end pulse it snapshots the live BCD score, compares it with a stored high score one digit per cycle, starting at the most significant digit, and replaces the high score if the new score is strictly greater. It also provides a display mux that selects either the live score or the high score for the seven-segment driver stage.

---
 rtl/high_score_keeper_if.sv | 28 ++
 rtl/high_score_keeper.sv | 113 +++++++++++
 tb/tb_high_score_keeper.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/high_score_keeper_if.sv
// high_score_keeper_if
//   Bundles the score/display signals of high_score_keeper.
//   master: drives score_digits, game_end, clear_high, show_high;
//           observes high_digits, disp_digits, new_record, busy, done.
//   slave : the keeper itself (mirror directions).
interface high_score_keeper_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] score_digits;
    logic                    game_end;
    logic                    clear_high;
    logic                    show_high;
    logic [4*NUM_DIGITS-1:0] high_digits;
    logic [4*NUM_DIGITS-1:0] disp_digits;
    logic                    new_record;
    logic                    busy;
    logic                    done;

    modport master (
        output score_digits, game_end, clear_high, show_high,
        input  high_digits, disp_digits, new_record, busy, done
    );

    modport slave (
        input  score_digits, game_end, clear_high, show_high,
        output high_digits, disp_digits, new_record, busy, done
    );
endinterface

// File: rtl/high_score_keeper.sv
// high_score_keeper
//   On a game_end pulse, snapshots the live BCD score and compares it with the
//   stored high score one digit per cycle, most significant digit first. A
//   strictly greater score replaces the high score and raises new_record.
//   Also muxes live/high score onto disp_digits for the display stage.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - high_score_keeper_if.slave: score_digits, game_end, clear_high,
//          show_high in; high_digits, disp_digits, new_record, busy, done out
module high_score_keeper #(
    parameter int NUM_DIGITS = 4
) (
    input logic                clk,
    input logic                rst,
    high_score_keeper_if.slave bus
);
    localparam int W     = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] MSD_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, COMPARE, UPDATE, DONE} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     high_q, high_d;
    logic [W-1:0]     snap_q, snap_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             new_record_q, new_record_d;
    logic [3:0]       snap_dig, high_dig;

    // Digit currently under comparison
    always_comb begin
        snap_dig = '0;
        high_dig = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                snap_dig = snap_q[4*i +: 4];
                high_dig = high_q[4*i +: 4];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            high_q       <= '0;
            snap_q       <= '0;
            idx_q        <= '0;
            new_record_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            high_q       <= high_d;
            snap_q       <= snap_d;
            idx_q        <= idx_d;
            new_record_q <= new_record_d;
        end
    end

    // Next-state logic; clear_high overrides every state
    always_comb begin
        state_d      = state_q;
        high_d       = high_q;
        snap_d       = snap_q;
        idx_d        = idx_q;
        new_record_d = new_record_q;
        if (bus.clear_high) begin
            high_d       = '0;
            new_record_d = 1'b0;
            state_d      = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.game_end) begin
                        snap_d       = bus.score_digits;
                        idx_d        = MSD_IDX;
                        new_record_d = 1'b0;
                        state_d      = COMPARE;
                    end
                end
                COMPARE: begin
                    if (snap_dig > high_dig) begin
                        state_d = UPDATE;
                    end else if (snap_dig < high_dig) begin
                        state_d = DONE;
                    end else if (idx_q != '0) begin
                        idx_d = idx_q - 1'b1;
                    end else begin
                        state_d = DONE;  // full tie is not a record
                    end
                end
                UPDATE: begin
                    high_d       = snap_q;
                    new_record_d = 1'b1;
                    state_d      = DONE;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        bus.busy        = (state_q != IDLE);
        bus.done        = (state_q == DONE);
        bus.high_digits = high_q;
        bus.new_record  = new_record_q;
        bus.disp_digits = bus.show_high ? high_q : bus.score_digits;
    end
endmodule

// File: tb/tb_high_score_keeper.sv
// tb_high_score_keeper
//   Scoreboard bench for high_score_keeper: each accepted game pushes its
//   predicted high score, new_record value and done latency; the entry is
//   popped and compared when done is observed.
module tb_high_score_keeper;
    localparam int ND = 4;
    localparam int W  = 4 * ND;

    typedef struct {
        logic [W-1:0] high;
        logic         nr;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    high_score_keeper_if #(.NUM_DIGITS(ND)) bus ();

    high_score_keeper #(.NUM_DIGITS(ND)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] model_high = '0;
    logic         model_nr   = 1'b0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Digit-serial compare model: first differing digit from the MSD decides
    function automatic exp_t predict(input logic [W-1:0] snap, input logic [W-1:0] high);
        exp_t       e;
        logic [3:0] s, h;
        bit         found;
        e.high = high;
        e.nr   = 1'b0;
        e.lat  = ND;
        found  = 0;
        for (int i = ND - 1; i >= 0; i--) begin
            s = snap[4*i +: 4];
            h = high[4*i +: 4];
            if (!found && s != h) begin
                found = 1;
                if (s > h) begin
                    e.high = snap;
                    e.nr   = 1'b1;
                    e.lat  = (ND - i) + 1;
                end else begin
                    e.lat = ND - i;
                end
            end
        end
        return e;
    endfunction

    task automatic start_game(input logic [W-1:0] score);
        bus.score_digits = score;
        bus.game_end     = 1'b1;
        tick();
        bus.game_end = 1'b0;
        sb.push_back(predict(score, model_high));
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_start: got %b expected 1", bus.busy);
        end
    endtask

    task automatic finish_game(input string name, input bit scramble, input int elapsed);
        exp_t e;
        bit   seen;
        int   cyc;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard: queue empty, expected an entry", name);
            return;
        end
        e    = sb.pop_front();
        seen = 0;
        cyc  = 0;
        for (int c = elapsed + 1; c <= 20 && !seen; c++) begin
            if (scramble) bus.score_digits = W'($urandom);
            tick();
            if (bus.done === 1'b1) begin
                seen = 1;
                cyc  = c;
            end
        end
        checks++;
        if (!seen || cyc != e.lat) begin
            errors++;
            $display("FAIL %s_latency: done after %0d cycles (seen=%0d) expected %0d", name, cyc, seen, e.lat);
        end
        checks++;
        if (bus.high_digits !== e.high) begin
            errors++;
            $display("FAIL %s_high: got %h expected %h", name, bus.high_digits, e.high);
        end
        checks++;
        if (bus.new_record !== e.nr) begin
            errors++;
            $display("FAIL %s_new_record: got %b expected %b", name, bus.new_record, e.nr);
        end
        model_high = e.high;
        model_nr   = e.nr;
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: done=%b busy=%b expected 0 0", name, bus.done, bus.busy);
        end
    endtask

    task automatic expect_no_done(input string name, input int cycles);
        bit bad;
        bad = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (bus.done !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s: got done pulse, expected none", name);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.score_digits = 16'h5678;
        bus.game_end     = 1'b0;
        bus.clear_high   = 1'b0;
        bus.show_high    = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (bus.high_digits !== '0 || bus.new_record !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: high=%h nr=%b expected 0000 0", bus.high_digits, bus.new_record);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
        checks++;
        if (bus.disp_digits !== '0) begin
            errors++;
            $display("FAIL reset_disp: got %h expected 0000", bus.disp_digits);
        end
        model_high = '0;
        model_nr   = 1'b0;
    endtask

    task automatic test_new_record;
        start_game(16'h0123);
        finish_game("new_record", 0, 0);
    endtask

    task automatic test_less;
        start_game(16'h0099);
        finish_game("less", 0, 0);
    endtask

    task automatic test_tie;
        start_game(16'h0123);
        finish_game("tie", 0, 0);
        start_game(16'h0124);
        finish_game("lsd_greater", 0, 0);
    endtask

    task automatic test_non_bcd;
        start_game(16'h01A0);
        finish_game("non_bcd", 0, 0);
    endtask

    task automatic test_display;
        bus.show_high    = 1'b0;
        bus.score_digits = 16'h4321;
        #1;
        checks++;
        if (bus.disp_digits !== 16'h4321) begin
            errors++;
            $display("FAIL disp_live: got %h expected 4321", bus.disp_digits);
        end
        bus.show_high = 1'b1;
        #1;
        checks++;
        if (bus.disp_digits !== model_high) begin
            errors++;
            $display("FAIL disp_high: got %h expected %h", bus.disp_digits, model_high);
        end
    endtask

    task automatic test_back_to_back;
        start_game(16'h0500);
        bus.score_digits = 16'h0000;
        bus.game_end     = 1'b1;
        tick();
        bus.game_end = 1'b0;
        finish_game("ignored_game_end", 0, 1);
        expect_no_done("single_done", 6);
    endtask

    task automatic test_clear;
        start_game(16'h0600);
        void'(sb.pop_front());
        bus.clear_high = 1'b1;
        tick();
        bus.clear_high = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.high_digits !== '0 || bus.new_record !== 1'b0) begin
            errors++;
            $display("FAIL clear_abort: busy=%b high=%h nr=%b expected 0 0000 0",
                     bus.busy, bus.high_digits, bus.new_record);
        end
        expect_no_done("clear_no_done", 6);
        model_high = '0;
        model_nr   = 1'b0;
        bus.score_digits = 16'h0777;
        bus.game_end     = 1'b1;
        bus.clear_high   = 1'b1;
        tick();
        bus.game_end   = 1'b0;
        bus.clear_high = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.high_digits !== '0) begin
            errors++;
            $display("FAIL clear_wins: busy=%b high=%h expected 0 0000", bus.busy, bus.high_digits);
        end
        expect_no_done("clear_wins_no_done", 6);
    endtask

    task automatic test_snapshot_and_async_rst;
        start_game(16'h0300);
        finish_game("pre_snapshot", 0, 0);
        start_game(16'h0250);
        finish_game("snapshot", 1, 0);
        start_game(16'h0400);
        void'(sb.pop_front());
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.high_digits !== '0 || bus.new_record !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: busy=%b high=%h nr=%b done=%b expected 0 0000 0 0",
                     bus.busy, bus.high_digits, bus.new_record, bus.done);
        end
        tick();
        rst = 1'b0;
        model_high = '0;
        model_nr   = 1'b0;
        expect_no_done("rst_no_done", 4);
    endtask

    initial begin
        bus.score_digits = '0;
        bus.game_end     = 1'b0;
        bus.clear_high   = 1'b0;
        bus.show_high    = 1'b0;
        test_reset();
        test_new_record();
        test_less();
        test_tie();
        test_non_bcd();
        test_display();
        test_back_to_back();
        test_clear();
        test_snapshot_and_async_rst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
